// File: rtl/fetch_if_stage.sv
// fetch_if_stage
//   Instruction-fetch stage plus IF/ID pipeline register for the LEGv8
//   pipeline. Owns the fetch PC, talks to instruction memory over a
//   req/ready handshake, applies hazard stalls, decode flushes and
//   taken-branch redirects, and parks one fetched word in a hold buffer
//   when decode is stalled so nothing is lost or delivered twice.
//
// Ports
//   clk            rising-edge clock
//   reset          asynchronous active-low reset
//   imem_req       fetch request valid
//   imem_addr      fetch address (current fetch PC)
//   imem_ready     memory accepts the request and returns imem_rdata
//   imem_rdata     instruction word, valid on accept
//   stall_F        hold IF/ID, do not advance
//   flush_D        squash IF/ID contents
//   branch_taken   one-cycle redirect pulse
//   branch_target  redirect address (low two bits ignored)
//   instr_D        IF/ID instruction
//   pc_D           IF/ID PC of instr_D
//   valid_D        instr_D is a real instruction

module fetch_if_stage #(
    parameter int          N        = 64,
    parameter logic [N-1:0] RESET_PC = '0
) (
    input  logic         clk,
    input  logic         reset,
    output logic         imem_req,
    output logic [N-1:0] imem_addr,
    input  logic         imem_ready,
    input  logic [31:0]  imem_rdata,
    input  logic         stall_F,
    input  logic         flush_D,
    input  logic         branch_taken,
    input  logic [N-1:0] branch_target,
    output logic [31:0]  instr_D,
    output logic [N-1:0] pc_D,
    output logic         valid_D
);

    typedef enum logic [1:0] {
        S_FETCH   = 2'd0,
        S_HELD    = 2'd1,
        S_DISCARD = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic [N-1:0]   pc_q, pc_d;
    logic [N-1:0]   pend_q, pend_d;
    logic [31:0]    buf_instr_q, buf_instr_d;
    logic [N-1:0]   buf_pc_q, buf_pc_d;
    logic [31:0]    instr_q, instr_d;
    logic [N-1:0]   pcd_q, pcd_d;
    logic           valid_q, valid_d;

    logic           accept;
    logic [N-1:0]   target;
    logic [N-1:0]   pc_inc;
    logic           load_ifid;
    logic [31:0]    load_instr;
    logic [N-1:0]   load_pc;

    assign accept = imem_req & imem_ready;
    assign target = {branch_target[N-1:2], 2'b00};
    assign pc_inc = pc_q + N'(4);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    state_d = accept ? S_FETCH : S_DISCARD;
                end else if (accept && stall_F) begin
                    state_d = S_HELD;
                end
            end
            S_HELD: begin
                if (branch_taken || !stall_F) begin
                    state_d = S_FETCH;
                end
            end
            S_DISCARD: begin
                // A redirect arriving together with the accept still drops
                // the data; the newest target is applied below.
                if (accept) begin
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Outputs: request is forced low combinationally while reset is held
    always_comb begin
        imem_req  = reset & (state_q != S_HELD);
        imem_addr = pc_q;
        instr_D   = instr_q;
        pc_D      = pcd_q;
        valid_D   = valid_q;
    end

    // Datapath next-state
    always_comb begin
        pc_d        = pc_q;
        pend_d      = pend_q;
        buf_instr_d = buf_instr_q;
        buf_pc_d    = buf_pc_q;
        load_ifid   = 1'b0;
        load_instr  = imem_rdata;
        load_pc     = pc_q;

        case (state_q)
            S_FETCH: begin
                if (branch_taken) begin
                    // Address must stay stable until accept, so an
                    // un-accepted request keeps pc_q and the target waits.
                    if (accept) pc_d   = target;
                    else        pend_d = target;
                end else if (accept) begin
                    pc_d = pc_inc;
                    if (stall_F) begin
                        buf_instr_d = imem_rdata;
                        buf_pc_d    = pc_q;
                    end else begin
                        load_ifid = 1'b1;
                    end
                end
            end
            S_HELD: begin
                // Buffer occupancy is the state itself, so leaving HELD on
                // a redirect is enough to drop the parked word.
                if (branch_taken) begin
                    pc_d = target;
                end else if (!stall_F) begin
                    load_ifid  = 1'b1;
                    load_instr = buf_instr_q;
                    load_pc    = buf_pc_q;
                end
            end
            S_DISCARD: begin
                if (branch_taken) begin
                    if (accept) pc_d   = target;
                    else        pend_d = target;
                end else if (accept) begin
                    pc_d = pend_q;
                end
            end
            default: ;
        endcase

        instr_d = instr_q;
        pcd_d   = pcd_q;
        valid_d = valid_q;
        if (flush_D) begin
            instr_d = '0;
            valid_d = 1'b0;
        end else if (!stall_F) begin
            if (load_ifid) begin
                instr_d = load_instr;
                pcd_d   = load_pc;
                valid_d = 1'b1;
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q        <= RESET_PC;
            pend_q      <= '0;
            buf_instr_q <= '0;
            buf_pc_q    <= '0;
            instr_q     <= '0;
            pcd_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            pc_q        <= pc_d;
            pend_q      <= pend_d;
            buf_instr_q <= buf_instr_d;
            buf_pc_q    <= buf_pc_d;
            instr_q     <= instr_d;
            pcd_q       <= pcd_d;
            valid_q     <= valid_d;
        end
    end

endmodule

// File: tb/tb_fetch_if_stage.sv
module tb_fetch_if_stage;

    logic        clk;
    logic        reset;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall_F;
    logic        flush_D;
    logic        branch_taken;
    logic [63:0] branch_target;
    logic [31:0] instr_D;
    logic [63:0] pc_D;
    logic        valid_D;

    logic        rst2;
    logic        req2;
    logic [63:0] addr2;
    logic        ready2;
    logic [31:0] rdata2;
    logic        zero1;
    logic [63:0] zero64;
    logic [31:0] instr2;
    logic [63:0] pcd2;
    logic        valid2;

    int n_checks;
    int n_pass;

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (a == 64'd0) return 32'h8B02_0020;
        if (a == 64'd4) return 32'h8B03_0041;
        return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0000;
    endfunction

    assign imem_rdata = mem_word(imem_addr);
    assign rdata2     = mem_word(addr2);

    fetch_if_stage #(.N(64), .RESET_PC(64'd0)) dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ready(imem_ready), .imem_rdata(imem_rdata),
        .stall_F(stall_F), .flush_D(flush_D),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .instr_D(instr_D), .pc_D(pc_D), .valid_D(valid_D)
    );

    fetch_if_stage #(.N(64), .RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut2 (
        .clk(clk), .reset(rst2),
        .imem_req(req2), .imem_addr(addr2),
        .imem_ready(ready2), .imem_rdata(rdata2),
        .stall_F(zero1), .flush_D(zero1),
        .branch_taken(zero1), .branch_target(zero64),
        .instr_D(instr2), .pc_D(pcd2), .valid_D(valid2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall_F       = 1'b0;
        flush_D       = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 64'd0;
    endtask

    // Reset dut, release one time unit after an edge; next edge is edge 1.
    task automatic restart();
        clear_inputs();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        imem_ready = 1'b1;
        reset = 1'b0;
        tick();
        tick();
        n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b want 0", imem_req); else n_pass++;
        n_checks++; if (valid_D !== 1'b0) $display("FAIL reset_valid: got %0b want 0", valid_D); else n_pass++;
        n_checks++; if (instr_D !== 32'd0) $display("FAIL reset_instr: got %h want 0", instr_D); else n_pass++;
        n_checks++; if (pc_D !== 64'd0) $display("FAIL reset_pcD: got %h want 0", pc_D); else n_pass++;
        reset = 1'b1;
        #1;
        n_checks++; if (imem_req !== 1'b1) $display("FAIL release_req: got %0b want 1", imem_req); else n_pass++;
        n_checks++; if (imem_addr !== 64'd0) $display("FAIL release_addr: got %h want 0", imem_addr); else n_pass++;
        tick();
        n_checks++; if ({valid_D, instr_D, pc_D} !== {1'b1, 32'h8B02_0020, 64'd0})
            $display("FAIL edge1: got v=%0b i=%h pc=%h want v=1 i=8b020020 pc=0", valid_D, instr_D, pc_D); else n_pass++;
        tick();
        n_checks++; if ({valid_D, instr_D, pc_D} !== {1'b1, 32'h8B03_0041, 64'd4})
            $display("FAIL edge2: got v=%0b i=%h pc=%h want v=1 i=8b030041 pc=4", valid_D, instr_D, pc_D); else n_pass++;
    endtask

    task automatic test_ready_delay();
        restart();
        for (int k = 0; k < 3; k++) begin
            imem_ready = 1'b0;
            for (int w = 0; w < 2; w++) begin
                tick();
                n_checks++; if ({imem_req, imem_addr} !== {1'b1, 64'(4 * k)})
                    $display("FAIL delay_addr k=%0d: got req=%0b addr=%h want req=1 addr=%h", k, imem_req, imem_addr, 4 * k); else n_pass++;
                n_checks++; if (valid_D !== 1'b0) $display("FAIL delay_bubble k=%0d: got %0b want 0", k, valid_D); else n_pass++;
            end
            imem_ready = 1'b1;
            tick();
            n_checks++; if ({valid_D, pc_D, instr_D} !== {1'b1, 64'(4 * k), mem_word(64'(4 * k))})
                $display("FAIL delay_deliver k=%0d: got v=%0b pc=%h i=%h", k, valid_D, pc_D, instr_D); else n_pass++;
        end
    endtask

    task automatic test_stall_held();
        restart();
        imem_ready = 1'b1;
        tick();
        tick();
        stall_F = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick();
            n_checks++; if ({valid_D, pc_D} !== {1'b1, 64'd4})
                $display("FAIL stall_hold s=%0d: got v=%0b pc=%h want v=1 pc=4", s, valid_D, pc_D); else n_pass++;
            n_checks++; if ({imem_req, imem_addr} !== {1'b0, 64'd12})
                $display("FAIL stall_req s=%0d: got req=%0b addr=%h want req=0 addr=c", s, imem_req, imem_addr); else n_pass++;
        end
        stall_F = 1'b0;
        tick();
        n_checks++; if ({valid_D, pc_D, instr_D} !== {1'b1, 64'd8, mem_word(64'd8)})
            $display("FAIL held_release: got v=%0b pc=%h i=%h want pc=8", valid_D, pc_D, instr_D); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 64'd12})
            $display("FAIL held_refetch: got req=%0b addr=%h want req=1 addr=c", imem_req, imem_addr); else n_pass++;
        tick();
        n_checks++; if ({valid_D, pc_D} !== {1'b1, 64'd12})
            $display("FAIL held_next: got v=%0b pc=%h want pc=c", valid_D, pc_D); else n_pass++;
    endtask

    task automatic test_branch_wait();
        restart();
        imem_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        imem_ready    = 1'b0;
        branch_taken  = 1'b1;
        flush_D       = 1'b1;
        branch_target = 64'h103;
        tick();
        clear_inputs();
        n_checks++; if ({valid_D, instr_D} !== 33'd0)
            $display("FAIL br_flush: got v=%0b i=%h want 0", valid_D, instr_D); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 64'h10})
            $display("FAIL br_addr_hold: got req=%0b addr=%h want 10", imem_req, imem_addr); else n_pass++;
        tick();
        n_checks++; if ({valid_D, imem_addr} !== {1'b0, 64'h10})
            $display("FAIL br_wait: got v=%0b addr=%h want v=0 addr=10", valid_D, imem_addr); else n_pass++;
        imem_ready = 1'b1;
        tick();
        n_checks++; if ({valid_D, imem_addr} !== {1'b0, 64'h100})
            $display("FAIL br_drop: got v=%0b addr=%h want v=0 addr=100", valid_D, imem_addr); else n_pass++;
        tick();
        n_checks++; if ({valid_D, pc_D, instr_D} !== {1'b1, 64'h100, mem_word(64'h100)})
            $display("FAIL br_target: got v=%0b pc=%h i=%h want pc=100", valid_D, pc_D, instr_D); else n_pass++;
    endtask

    task automatic test_branch_held();
        restart();
        imem_ready = 1'b1;
        tick();
        tick();
        stall_F = 1'b1;
        tick();
        branch_taken  = 1'b1;
        flush_D       = 1'b1;
        branch_target = 64'h200;
        tick();
        n_checks++; if ({valid_D, instr_D} !== 33'd0)
            $display("FAIL held_br_flush: got v=%0b i=%h want 0", valid_D, instr_D); else n_pass++;
        n_checks++; if ({imem_req, imem_addr} !== {1'b1, 64'h200})
            $display("FAIL held_br_addr: got req=%0b addr=%h want 200", imem_req, imem_addr); else n_pass++;
        clear_inputs();
        tick();
        n_checks++; if ({valid_D, pc_D} !== {1'b1, 64'h200})
            $display("FAIL held_br_resume: got v=%0b pc=%h want pc=200", valid_D, pc_D); else n_pass++;
        tick();
        n_checks++; if ({valid_D, pc_D} !== {1'b1, 64'h204})
            $display("FAIL held_br_next: got v=%0b pc=%h want pc=204", valid_D, pc_D); else n_pass++;
    endtask

    task automatic test_wrap_and_midreset();
        logic [63:0] exp_seq [3];
        exp_seq[0] = 64'hFFFF_FFFF_FFFF_FFFC;
        exp_seq[1] = 64'd0;
        exp_seq[2] = 64'd4;
        ready2 = 1'b1;
        rst2   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if ({valid2, pcd2, instr2} !== {1'b1, exp_seq[i], mem_word(exp_seq[i])})
                $display("FAIL wrap_%0d: got v=%0b pc=%h i=%h want pc=%h", i, valid2, pcd2, instr2, exp_seq[i]); else n_pass++;
        end
        ready2 = 1'b0;
        tick();
        #2 rst2 = 1'b0;
        #1;
        n_checks++; if ({req2, valid2, instr2, pcd2} !== 98'd0)
            $display("FAIL midreset_out: got req=%0b v=%0b i=%h pc=%h want 0", req2, valid2, instr2, pcd2); else n_pass++;
        n_checks++; if (addr2 !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL midreset_addr: got %h want fffffffffffffffc", addr2); else n_pass++;
        #1 rst2 = 1'b1;
        ready2 = 1'b1;
        tick();
        n_checks++; if ({valid2, pcd2} !== {1'b1, 64'hFFFF_FFFF_FFFF_FFFC})
            $display("FAIL midreset_restart: got v=%0b pc=%h want fffffffffffffffc", valid2, pcd2); else n_pass++;
    endtask

    // Program-order model: every delivered word must be the next sequential
    // PC of the current stream; a redirect restarts the stream at its target.
    task automatic test_random();
        logic [63:0] exp_pc;
        int          deliv;
        int          errs;
        logic        p_req, p_ready, p_stall, p_flush, p_br, p_valid;
        logic [63:0] p_addr, p_tgt, p_pcd;
        logic [31:0] p_instr;
        restart();
        exp_pc = 64'd0;
        deliv  = 0;
        errs   = 0;
        for (int c = 0; c < 3000; c++) begin
            stall_F       = ($urandom % 4) == 0;
            imem_ready    = ($urandom % 3) != 0;
            branch_taken  = ($urandom % 40) == 0;
            flush_D       = branch_taken;
            branch_target = {$urandom, $urandom};
            p_req = imem_req;  p_ready = imem_ready; p_addr = imem_addr;
            p_stall = stall_F; p_flush = flush_D;    p_br = branch_taken;
            p_tgt = branch_target;
            p_valid = valid_D; p_pcd = pc_D;         p_instr = instr_D;
            tick();
            if (errs < 20) begin
                if (p_req && !p_ready) begin
                    n_checks++; if ({imem_req, imem_addr} !== {1'b1, p_addr}) begin
                        $display("FAIL rnd_addr_stable c=%0d: got req=%0b addr=%h want addr=%h", c, imem_req, imem_addr, p_addr); errs++;
                    end else n_pass++;
                end
                if (p_flush) begin
                    n_checks++; if ({valid_D, instr_D} !== 33'd0) begin
                        $display("FAIL rnd_flush c=%0d: got v=%0b i=%h", c, valid_D, instr_D); errs++;
                    end else n_pass++;
                end else if (p_stall) begin
                    n_checks++; if ({valid_D, pc_D, instr_D} !== {p_valid, p_pcd, p_instr}) begin
                        $display("FAIL rnd_stall_hold c=%0d: got v=%0b pc=%h want v=%0b pc=%h", c, valid_D, pc_D, p_valid, p_pcd); errs++;
                    end else n_pass++;
                end else if (valid_D) begin
                    deliv++;
                    n_checks++; if ({pc_D, instr_D} !== {exp_pc, mem_word(exp_pc)}) begin
                        $display("FAIL rnd_deliver c=%0d: got pc=%h i=%h want pc=%h", c, pc_D, instr_D, exp_pc); errs++;
                    end else n_pass++;
                    exp_pc = exp_pc + 64'd4;
                end
            end
            if (p_br) exp_pc = {p_tgt[63:2], 2'b00};
        end
        clear_inputs();
        n_checks++; if (deliv < 500) $display("FAIL rnd_progress: got %0d deliveries want >= 500", deliv); else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        zero1    = 1'b0;
        zero64   = 64'd0;
        rst2     = 1'b0;
        ready2   = 1'b0;
        reset    = 1'b0;
        imem_ready = 1'b0;
        clear_inputs();
        test_reset();
        test_ready_delay();
        test_stall_held();
        test_branch_wait();
        test_branch_held();
        test_wrap_and_midreset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_if_stage.md
Name: fetch_if_stage

Overview:
Instruction-fetch stage and IF/ID pipeline register that produces the instruction word and PC consumed by the decode stage of the LEGv8 pipelined processor. It owns the program counter and issues requests to instruction memory over a req/ready handshake. It applies hazard-unit stalls, flushes and taken-branch redirects. A one-entry hold buffer ensures no fetched instruction is lost or duplicated.

Parameters:
N, 64, datapath/PC width in bits
RESET_PC, 0, PC value loaded on reset (word aligned)

Ports:
clk  input  1  clock, rising edge
reset  input  1  asynchronous, active-low reset
imem_req  output  1  fetch request valid
imem_addr  output  N  fetch address (= pc_F)
imem_ready  input  1  memory accepts req and returns imem_rdata this cycle
imem_rdata  input  32  instruction word, valid when imem_req && imem_ready
stall_F  input  1  hazard unit: hold IF/ID and do not advance
flush_D  input  1  squash IF/ID contents (bubble into decode)
branch_taken  input  1  one-cycle redirect pulse from MEM stage
branch_target  input  N  redirect address
instr_D  output  32  IF/ID instruction to decode
pc_D  output  N  IF/ID PC of instr_D
valid_D  output  1  instr_D is a real instruction

Behaviour:
- Reset (reset=0, async): pc_F=RESET_PC, state=FETCH, instr_D=0, pc_D=0, valid_D=0, hold buffer empty, imem_req=0 while reset is low. imem_req rises in the first cycle after release.
- Accept event: imem_req && imem_ready at a rising edge. imem_addr stays stable from req assertion until accept.
- States: FETCH (req=1), HELD (req=0, buffer full), DISCARD (req=1, response to be dropped).
- FETCH, accept, !stall_F: IF/ID <= {imem_rdata, pc_F}, valid_D<=1, pc_F<=pc_F+4.
- FETCH, accept, stall_F: IF/ID holds. Buffer <= {imem_rdata, pc_F}, pc_F<=pc_F+4, go to HELD.
- FETCH, no accept, !stall_F: valid_D<=0 (bubble), IF/ID instr/pc unchanged.
- Any state with stall_F=1 (and no flush): IF/ID fully holds.
- HELD, !stall_F: IF/ID <= buffer, valid_D<=1, buffer empties, go to FETCH. Latency of a stalled instruction into decode is exactly 1 cycle after stall_F drops.
- flush_D: at the next edge valid_D<=0 and instr_D<=0. pc_D is don't-care. flush_D overrides stall_F for IF/ID. The HELD buffer is not affected by flush_D alone.
- branch_taken (priority over stall_F and normal flow; target uses branch_target with bits[1:0] forced to 0):
  - FETCH with accept this cycle: drop imem_rdata, pc_F<=target, stay FETCH.
  - FETCH without accept: pending_target<=target, go to DISCARD. The old address is held until accept, then the data is dropped, pc_F<=pending_target, go to FETCH.
  - DISCARD with another branch_taken: pending_target is overwritten. Last redirect wins.
  - HELD: buffer is emptied, pc_F<=target, go to FETCH.
  - branch_taken never writes IF/ID by itself. The caller pairs it with flush_D.
- PC arithmetic is modulo 2^N: pc_F=2^N-4 increments to 0.
- No instruction is delivered twice. No accepted, non-redirected instruction is skipped.
- Reset asserted mid-request: req drops immediately (async). The outstanding response is ignored and memory must tolerate the abandoned request.

Test Plan:
- Reset release, imem_ready=1 always, rdata=0x8B020020 at 0, 0x8B030041 at 4 -> valid_D=0 after reset; instr_D=0x8B020020/pc_D=0 at edge 1, 0x8B030041/pc_D=4 at edge 2.
- Memory ready delayed 3 cycles per fetch -> imem_addr stable during the wait, valid_D=0 bubbles for 2 cycles per instruction, pc_D sequence 0,4,8.
- stall_F=1 for 4 cycles while the accept at pc=8 happens -> IF/ID holds pc_D=4, req=0 in HELD, pc_D=8 one cycle after stall_F drops, next fetch at 12, no duplicate.
- branch_taken+flush_D with target 0x103 while a fetch at 0x10 waits (ready late) -> addr stays 0x10 until accept, data dropped, next addr 0x100, valid_D=0 until the 0x100 instruction arrives.
- branch_taken while HELD plus flush_D with stall_F=1 -> valid_D=0 next edge, buffer dropped, fetch resumes at target.
- RESET_PC=64'hFFFF_FFFF_FFFF_FFFC, ready=1 -> pc_D sequence ...FFFC then 0; reset pulsed mid-wait -> outputs zero asynchronously, fetch restarts at RESET_PC.
